bexkat1_exec_unit: RTL and testbench

- Parametrised execute stage for the bexkat1 pipeline, sitting between decode/register-read and memory access.
- Adds valid/ready handshakes on both sides, a configurable integer (mul/div) latency, a datapath width parameter, and a flush input for branch/exception squash.
- Computes ALU and integer results, load/store addresses, condition codes, and branch/jump targets.

---
 rtl/bexkat1_exec_unit_pkg.sv | 24 ++
 rtl/alu_comb.sv | 26 ++
 rtl/bexkat1_brcond.sv | 26 ++
 rtl/intcalc.sv | 34 +++
 rtl/bexkat1_exec_unit.sv | 166 ++++++++++++++++
 tb/tb_bexkat1_exec_unit.sv | 298 +++++++++++++++++++++++++++++
 6 files changed

// File: rtl/bexkat1_exec_unit_pkg.sv
// Shared types for the bexkat1 execute stage: instruction classes,
// ALU/INT function codes and the execute FSM state.
package bexkat1Def;
  typedef enum logic [3:0] {
    T_INH = 4'h0, T_PUSH = 4'h1, T_POP = 4'h2, T_CMP = 4'h3,
    T_MOV = 4'h4, T_INTU = 4'h5, T_INT = 4'h6, T_ALU = 4'h7,
    T_LDI = 4'h8, T_LOAD = 4'h9, T_STORE = 4'ha, T_BRANCH = 4'hb,
    T_JUMP = 4'hc, T_RSV_D = 4'hd, T_RSV_E = 4'he, T_RSV_F = 4'hf
  } insn_t;

  typedef enum logic [2:0] {
    ALU_AND, ALU_OR, ALU_ADD, ALU_SUB,
    ALU_LSHIFT, ALU_RSHIFTA, ALU_RSHIFTL, ALU_XOR
  } alufunc_t;

  typedef enum logic [2:0] {
    INT_MUL, INT_DIV, INT_MOD, INT_MULU,
    INT_DIVU, INT_MODU, INT_MULX, INT_MULUX
  } intfunc_t;

  typedef enum logic {S_RUN, S_INT} exec_state_t;

  localparam logic [3:0] OP_HALT = 4'h4;
endpackage

// File: rtl/alu_comb.sv
// Combinational ALU; shift amount uses the low log2(DW) bits of b.
module alu_comb import bexkat1Def::*; #(
  parameter int DW = 32
) (
  input  alufunc_t      func,
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  output logic [DW-1:0] y
);
  localparam int SW = $clog2(DW);
  logic [SW-1:0] sh;
  assign sh = b[SW-1:0];

  always_comb begin
    case (func)
      ALU_AND:     y = a & b;
      ALU_OR:      y = a | b;
      ALU_ADD:     y = a + b;
      ALU_SUB:     y = a - b;
      ALU_LSHIFT:  y = a << sh;
      ALU_RSHIFTA: y = $signed(a) >>> sh;
      ALU_RSHIFTL: y = a >> sh;
      default:     y = a ^ b;
    endcase
  end
endmodule

// File: rtl/bexkat1_brcond.sv
// Branch-taken decision from condition codes {ltu, lt, eq}.
module bexkat1_brcond (
  input  logic [2:0] ccr,
  input  logic [3:0] op,
  output logic       taken
);
  logic ltu, lt, eq;
  assign {ltu, lt, eq} = ccr;

  always_comb begin
    case (op)
      4'h0:    taken = 1'b1;
      4'h1:    taken = eq;
      4'h2:    taken = !eq;
      4'h3:    taken = !(ltu | eq);
      4'h4:    taken = !(lt | eq);
      4'h5:    taken = !lt;
      4'h6:    taken = lt | eq;
      4'h7:    taken = lt;
      4'h8:    taken = !ltu;
      4'h9:    taken = ltu;
      4'ha:    taken = ltu | eq;
      default: taken = 1'b0;
    endcase
  end
endmodule

// File: rtl/intcalc.sv
// Integer multiply/divide unit. Divide by zero yields all-ones quotient
// and the dividend as remainder so the result is always defined.
module intcalc import bexkat1Def::*; #(
  parameter int DW = 32
) (
  input  intfunc_t      func,
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  output logic [DW-1:0] y
);
  logic [2*DW-1:0] sprod, uprod;
  logic [DW-1:0]   squo, srem, uquo, urem;
  logic            dz;

  always_comb begin
    sprod = {{DW{a[DW-1]}}, a} * {{DW{b[DW-1]}}, b};
    uprod = {{DW{1'b0}}, a} * {{DW{1'b0}}, b};
    dz    = (b == '0);
    squo  = dz ? '1 : $signed(a) / $signed(b);
    srem  = dz ? a  : $signed(a) % $signed(b);
    uquo  = dz ? '1 : a / b;
    urem  = dz ? a  : a % b;
    case (func)
      INT_MUL:   y = sprod[DW-1:0];
      INT_MULU:  y = uprod[DW-1:0];
      INT_DIV:   y = squo;
      INT_MOD:   y = srem;
      INT_DIVU:  y = uquo;
      INT_MODU:  y = urem;
      INT_MULX:  y = sprod[2*DW-1:DW];
      default:   y = uprod[2*DW-1:DW];
    endcase
  end
endmodule

// File: rtl/bexkat1_exec_unit.sv
// bexkat1 execute stage: valid/ready both sides, multi-cycle INT ops,
// condition codes, branch/jump redirect, sticky halt and flush.
module bexkat1_exec_unit import bexkat1Def::*; #(
  parameter int DW      = 32,
  parameter int INT_LAT = 4
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          in_valid_i,
  output logic          in_ready_o,
  input  logic [63:0]   ir_i,
  input  logic [DW-1:0] pc_i,
  input  logic [DW-1:0] rs1_i,
  input  logic [DW-1:0] rs2_i,
  input  logic [1:0]    reg_write_i,
  input  logic          flush_i,
  output logic          out_valid_o,
  input  logic          out_ready_i,
  output logic [63:0]   ir_o,
  output logic [DW-1:0] pc_o,
  output logic [DW-1:0] result_o,
  output logic [DW-1:0] rs1_o,
  output logic [1:0]    reg_write_o,
  output logic [2:0]    ccr_o,
  output logic          pc_set_o,
  output logic          halt_o,
  output logic          busy_o
);
  localparam int CW     = $clog2(INT_LAT + 1);
  localparam bit INT_MC = (INT_LAT > 1);

  exec_state_t   state, state_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic [63:0]   h_ir, s_ir;
  logic [DW-1:0] h_pc, h_rs1, h_rs2, s_pc, s_rs1, s_rs2;
  logic [1:0]    h_rw, s_rw;
  logic          slot_free, acc, is_int, int_done, load, taken, nx_set;
  insn_t         s_ty;
  logic [3:0]    s_op;
  logic [DW-1:0] sval, uval, sc, ext, alu_y, int_y, nx_res, nx_pc;
  logic [DW:0]   diff;
  logic [2:0]    ccr_nx;

  assign slot_free  = !out_valid_o || out_ready_i;
  assign in_ready_o = !flush_i && !halt_o && state == S_RUN && slot_free;
  assign acc        = in_valid_i && in_ready_o;
  assign busy_o     = (state == S_INT);

  // While an INT op is in flight the datapath works from the held copy.
  assign s_ir  = busy_o ? h_ir  : ir_i;
  assign s_pc  = busy_o ? h_pc  : pc_i;
  assign s_rs1 = busy_o ? h_rs1 : rs1_i;
  assign s_rs2 = busy_o ? h_rs2 : rs2_i;
  assign s_rw  = busy_o ? h_rw  : reg_write_i;

  assign s_ty     = insn_t'(s_ir[31:28]);
  assign s_op     = s_ir[27:24];
  assign is_int   = INT_MC && (s_ty == T_INT || s_ty == T_INTU);
  assign int_done = busy_o && cnt == CW'(1) && slot_free && !flush_i;
  assign load     = (acc && !is_int) || int_done;

  assign sval = DW'($signed(s_ir[15:1]));
  assign uval = DW'(s_ir[15:1]);
  assign sc   = sval << 2;
  assign ext  = DW'(s_ir[63:32]);

  assign diff   = {1'b0, s_rs1} - {1'b0, s_rs2};
  assign ccr_nx = {diff[DW],
                   diff[DW-1] ^ ((s_rs1[DW-1] ^ s_rs2[DW-1]) & (s_rs1[DW-1] ^ diff[DW-1])),
                   diff[DW-1:0] == '0};

  alu_comb #(.DW(DW)) u_alu (
    .func(alufunc_t'(s_op[2:0])), .a(s_rs1), .b(s_op[3] ? sval : s_rs2), .y(alu_y)
  );

  intcalc #(.DW(DW)) u_int (
    .func(intfunc_t'(s_op[2:0])), .a(s_rs1),
    .b(s_ty == T_INTU ? s_rs1 : (s_op[3] ? sc : s_rs2)), .y(int_y)
  );

  bexkat1_brcond u_br (.ccr(ccr_o), .op(s_op), .taken(taken));

  always_comb begin
    nx_res = '0;
    nx_pc  = s_pc;
    nx_set = 1'b0;
    case (s_ty)
      T_ALU:           nx_res = alu_y;
      T_CMP:           nx_res = diff[DW-1:0];
      T_LOAD, T_STORE: nx_res = s_ir[0] ? ext : sc + s_rs2;
      T_LDI:           nx_res = s_ir[0] ? ext : uval;
      T_MOV:           nx_res = s_rs1;
      T_INT, T_INTU:   nx_res = int_y;
      T_BRANCH: begin
        nx_set = taken;
        if (taken) nx_pc = s_pc + sc;
      end
      T_JUMP: begin
        nx_set = 1'b1;
        nx_pc  = s_ir[0] ? ext : s_rs2 + sc;
      end
      default: ;
    endcase
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    if (flush_i) begin
      state_nx = S_RUN;
      cnt_nx   = '0;
    end else begin
      case (state)
        S_RUN: if (acc && is_int) begin
          state_nx = S_INT;
          cnt_nx   = CW'(INT_LAT - 1);
        end
        S_INT: if (cnt == CW'(1)) begin
          if (slot_free) begin
            state_nx = S_RUN;
            cnt_nx   = '0;
          end
        end else cnt_nx = cnt - CW'(1);
        default: state_nx = S_RUN;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= S_RUN;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      out_valid_o <= 1'b0; ir_o <= '0; pc_o <= '0; result_o <= '0; rs1_o <= '0;
      reg_write_o <= '0; ccr_o <= '0; pc_set_o <= 1'b0; halt_o <= 1'b0;
      h_ir <= '0; h_pc <= '0; h_rs1 <= '0; h_rs2 <= '0; h_rw <= '0;
    end else if (flush_i) begin
      out_valid_o <= 1'b0;
      pc_set_o    <= 1'b0;
    end else begin
      if (load) begin
        out_valid_o <= 1'b1;
        ir_o        <= s_ir;
        pc_o        <= nx_pc;
        result_o    <= nx_res;
        rs1_o       <= s_rs1;
        reg_write_o <= s_rw;
        pc_set_o    <= nx_set;
      end else if (out_ready_i) begin
        out_valid_o <= 1'b0;
      end
      if (acc && is_int) begin
        h_ir <= ir_i; h_pc <= pc_i; h_rs1 <= rs1_i; h_rs2 <= rs2_i; h_rw <= reg_write_i;
      end
      if (acc && s_ty == T_CMP) ccr_o <= ccr_nx;
      if (acc && s_ty == T_INH && s_op == OP_HALT) halt_o <= 1'b1;
    end
  end
endmodule

// File: tb/tb_bexkat1_exec_unit.sv
// Directed + randomized bench for bexkat1_exec_unit against an arithmetic
// reference model; a second DW=64, INT_LAT=1 instance covers wide datapaths.
module tb_bexkat1_exec_unit;
  localparam int LAT = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  always #5 clk = ~clk;

  logic        in_valid = 1'b0, flush = 1'b0, out_ready = 1'b1;
  logic [63:0] ir = '0;
  logic [31:0] pc = '0, rs1 = '0, rs2 = '0;
  logic [1:0]  rw = '0;
  logic        in_ready, out_valid, pc_set, halt, busy;
  logic [63:0] ir_o;
  logic [31:0] pc_o, result, rs1_o;
  logic [1:0]  rw_o;
  logic [2:0]  ccr;

  logic        d_in_valid = 1'b0, d_flush = 1'b0, d_out_ready = 1'b1;
  logic [63:0] d_ir = '0, d_pc = '0, d_rs1 = '0, d_rs2 = '0;
  logic [1:0]  d_rw = '0;
  logic        d_in_ready, d_out_valid, d_pc_set, d_halt, d_busy;
  logic [63:0] d_ir_o, d_pc_o, d_result, d_rs1_o;
  logic [1:0]  d_rw_o;
  logic [2:0]  d_ccr;

  int ncmp = 0, nfail = 0;
  logic [31:0] m_a = 32'd1, m_b = 32'd0;  // operands of the last CMP (reset ccr = a > b)

  bexkat1_exec_unit #(.DW(32), .INT_LAT(LAT)) dut (
    .clk_i(clk), .rst_i(rst), .in_valid_i(in_valid), .in_ready_o(in_ready),
    .ir_i(ir), .pc_i(pc), .rs1_i(rs1), .rs2_i(rs2), .reg_write_i(rw),
    .flush_i(flush), .out_valid_o(out_valid), .out_ready_i(out_ready),
    .ir_o(ir_o), .pc_o(pc_o), .result_o(result), .rs1_o(rs1_o),
    .reg_write_o(rw_o), .ccr_o(ccr), .pc_set_o(pc_set), .halt_o(halt), .busy_o(busy)
  );

  bexkat1_exec_unit #(.DW(64), .INT_LAT(1)) dut64 (
    .clk_i(clk), .rst_i(rst), .in_valid_i(d_in_valid), .in_ready_o(d_in_ready),
    .ir_i(d_ir), .pc_i(d_pc), .rs1_i(d_rs1), .rs2_i(d_rs2), .reg_write_i(d_rw),
    .flush_i(d_flush), .out_valid_o(d_out_valid), .out_ready_i(d_out_ready),
    .ir_o(d_ir_o), .pc_o(d_pc_o), .result_o(d_result), .rs1_o(d_rs1_o),
    .reg_write_o(d_rw_o), .ccr_o(d_ccr), .pc_set_o(d_pc_set), .halt_o(d_halt), .busy_o(d_busy)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) tick();
  endtask

  function automatic logic [63:0] mk(input logic [3:0] ty, input logic [3:0] op,
                                     input logic [14:0] imm, input logic sz, input logic [31:0] ext);
    return {ext, ty, op, 8'h00, imm, sz};
  endfunction

  // Reference: what each instruction class should produce, from plain arithmetic.
  function automatic void model(input logic [63:0] i, input logic [31:0] pcv, a, b, ca, cb,
                                output logic [31:0] res, output bit def,
                                output logic [31:0] npc, output bit set, output int lat);
    logic [3:0]  ty, op;
    logic [31:0] sv, sc, ext, uv, y;
    logic [63:0] p;
    int sa, sb;
    bit tk;
    ty = i[31:28]; op = i[27:24];
    sv = int'($signed(i[15:1])); sc = sv * 4; ext = i[63:32]; uv = 32'(i[15:1]);
    res = '0; def = 1; npc = pcv; set = 0; lat = 1; tk = 0;
    case (ty)
      4'h7: begin
        y = op[3] ? sv : b;
        case (op[2:0])
          3'd0: res = a & y;
          3'd1: res = a | y;
          3'd2: res = a + y;
          3'd3: res = a - y;
          3'd4: res = a << (y % 32);
          3'd5: res = $signed(a) >>> (y % 32);
          3'd6: res = a >> (y % 32);
          default: res = a ^ y;
        endcase
      end
      4'h5, 4'h6: begin
        lat = LAT;
        y = (ty == 4'h5) ? a : (op[3] ? sc : b);
        sa = a; sb = y;
        case (op[2:0])
          3'd0, 3'd3: res = a * y;
          3'd1: res = (y == 0) ? 32'hffff_ffff : sa / sb;
          3'd2: res = (y == 0) ? a : sa % sb;
          3'd4: res = (y == 0) ? 32'hffff_ffff : a / y;
          3'd5: res = (y == 0) ? a : a % y;
          3'd6: begin p = longint'(sa) * longint'(sb); res = p[63:32]; end
          default: begin p = {32'b0, a} * {32'b0, y}; res = p[63:32]; end
        endcase
      end
      4'h3: def = 0;
      4'h4: res = a;
      4'h8: res = i[0] ? ext : uv;
      4'h9, 4'ha: res = i[0] ? ext : sc + b;
      4'hb: begin
        def = 0;
        case (op)
          4'h0: tk = 1;
          4'h1: tk = (ca == cb);
          4'h2: tk = (ca != cb);
          4'h3: tk = (ca > cb);
          4'h4: tk = ($signed(ca) > $signed(cb));
          4'h5: tk = ($signed(ca) >= $signed(cb));
          4'h6: tk = ($signed(ca) <= $signed(cb));
          4'h7: tk = ($signed(ca) < $signed(cb));
          4'h8: tk = (ca >= cb);
          4'h9: tk = (ca < cb);
          4'ha: tk = (ca <= cb);
          default: tk = 0;
        endcase
        set = tk;
        if (tk) npc = pcv + sc;
      end
      4'hc: begin def = 0; set = 1; npc = i[0] ? ext : b + sc; end
      default: def = 0;
    endcase
  endfunction

  // Send one op with out_ready high, wait for it to emerge, check everything.
  task automatic issue(input logic [63:0] i_ir, input logic [31:0] i_pc, i_a, i_b, input logic [1:0] i_rw);
    logic [31:0] e_res, e_pc;
    bit e_def, e_set;
    int e_lat, lat;
    model(i_ir, i_pc, i_a, i_b, m_a, m_b, e_res, e_def, e_pc, e_set, e_lat);
    ir = i_ir; pc = i_pc; rs1 = i_a; rs2 = i_b; rw = i_rw; in_valid = 1'b1;
    #1 chk("in_ready_idle", 64'(in_ready), 64'(1));
    tick();
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 12) begin
      chk("busy_wait", 64'(busy), 64'(1));
      chk("ready_while_busy", 64'(in_ready), 64'(0));
      tick();
      lat++;
    end
    if (i_ir[31:28] == 4'h3) begin m_a = i_a; m_b = i_b; end
    chk("latency", 64'(lat), 64'(e_lat));
    chk("out_valid", 64'(out_valid), 64'(1));
    if (e_def) chk("result", 64'(result), 64'(e_res));
    chk("pc_o", 64'(pc_o), 64'(e_pc));
    chk("pc_set", 64'(pc_set), 64'(e_set));
    chk("ir_o", ir_o, i_ir);
    chk("rs1_o", 64'(rs1_o), 64'(i_a));
    chk("reg_write_o", 64'(rw_o), 64'(i_rw));
    chk("ccr", 64'(ccr), 64'({m_a < m_b, $signed(m_a) < $signed(m_b), m_a == m_b}));
  endtask

  logic [3:0] tys [10] = '{4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'h8, 4'h9, 4'ha, 4'hb, 4'hc};

  initial begin
    logic [63:0] r_ir;
    logic [2:0]  ccr_before;

    // reset
    tick(); tick();
    rst = 1'b0;
    #1;
    chk("rst_out_valid", 64'(out_valid), 64'(0));
    chk("rst_result", 64'(result), 64'(0));
    chk("rst_pc_o", 64'(pc_o), 64'(0));
    chk("rst_ccr", 64'(ccr), 64'(0));
    chk("rst_halt", 64'(halt), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_in_ready", 64'(in_ready), 64'(1));

    // CMP 5,7 then BLT +4 words at 0x100
    issue(mk(4'h3, 4'h0, 15'd0, 1'b0, 32'd0), 32'h0, 32'd5, 32'd7, 2'd0);
    chk("cmp_ccr", 64'(ccr), 64'(3'b110));
    issue(mk(4'hb, 4'h7, 15'd4, 1'b0, 32'd0), 32'h100, 32'd0, 32'd0, 2'd0);
    chk("blt_pc", 64'(pc_o), 64'(32'h110));
    chk("blt_set", 64'(pc_set), 64'(1));

    // MUL 6*7
    issue(mk(4'h6, 4'h0, 15'd0, 1'b0, 32'd0), 32'h0, 32'd6, 32'd7, 2'd1);
    chk("mul_42", 64'(result), 64'(42));

    // backpressure on LDI ext
    idle(1);
    out_ready = 1'b0;
    ir = mk(4'h8, 4'h0, 15'd0, 1'b1, 32'hdeadbeef); in_valid = 1'b1;
    tick();
    ir = mk(4'h7, 4'h2, 15'd0, 1'b0, 32'd0); rs1 = 32'd3; rs2 = 32'd4;
    for (int k = 0; k < 3; k++) begin
      chk("bp_valid", 64'(out_valid), 64'(1));
      chk("bp_result", 64'(result), 64'(32'hdeadbeef));
      chk("bp_ready", 64'(in_ready), 64'(0));
      tick();
    end
    out_ready = 1'b1;
    #1 chk("bp_release_ready", 64'(in_ready), 64'(1));
    tick();
    in_valid = 1'b0;
    chk("bp_next_result", 64'(result), 64'(7));

    // flush two cycles into a MUL, with another op offered during flush
    idle(1);
    ccr_before = ccr;
    ir = mk(4'h6, 4'h0, 15'd0, 1'b0, 32'd0); rs1 = 32'd6; rs2 = 32'd7; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    chk("fl_busy_before", 64'(busy), 64'(1));
    flush = 1'b1;
    ir = mk(4'h3, 4'h0, 15'd0, 1'b0, 32'd0); rs1 = 32'd9; rs2 = 32'd9; in_valid = 1'b1;
    #1 chk("fl_ready", 64'(in_ready), 64'(0));
    tick();
    flush = 1'b0; in_valid = 1'b0;
    chk("fl_valid", 64'(out_valid), 64'(0));
    chk("fl_busy", 64'(busy), 64'(0));
    chk("fl_ccr", 64'(ccr), 64'(ccr_before));
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("fl_no_ghost", 64'(out_valid), 64'(0));
    end
    issue(mk(4'h7, 4'h2, 15'd0, 1'b0, 32'd0), 32'h40, 32'd1, 32'd1, 2'd2);
    chk("fl_add2", 64'(result), 64'(2));

    // flush drops a stalled jump's redirect
    idle(1);
    out_ready = 1'b0;
    ir = mk(4'hc, 4'h0, 15'd0, 1'b1, 32'h1234); in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("jmp_pc", 64'(pc_o), 64'(32'h1234));
    chk("jmp_set", 64'(pc_set), 64'(1));
    flush = 1'b1;
    tick();
    flush = 1'b0; out_ready = 1'b1;
    chk("fl_jmp_valid", 64'(out_valid), 64'(0));
    chk("fl_jmp_set", 64'(pc_set), 64'(0));

    // random ops
    for (int n = 0; n < 150; n++) begin
      r_ir = mk(tys[$urandom_range(0, 9)], 4'($urandom), 15'($urandom), 1'($urandom), $urandom);
      r_ir[23:16] = 8'($urandom);
      issue(r_ir, $urandom, $urandom, $urandom, 2'($urandom));
    end

    // halt with further ops pending
    ir = mk(4'h0, 4'h4, 15'd0, 1'b0, 32'd0); in_valid = 1'b1;
    tick();
    chk("halt_set", 64'(halt), 64'(1));
    ir = mk(4'h7, 4'h2, 15'd0, 1'b0, 32'd0);
    for (int k = 0; k < 4; k++) begin
      chk("halt_ready", 64'(in_ready), 64'(0));
      chk("halt_sticky", 64'(halt), 64'(1));
      tick();
    end
    chk("halt_drained", 64'(out_valid), 64'(0));
    in_valid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst2_halt", 64'(halt), 64'(0));
    chk("rst2_pc_o", 64'(pc_o), 64'(0));
    chk("rst2_result", 64'(result), 64'(0));
    chk("rst2_ir_o", ir_o, 64'(0));
    chk("rst2_ccr", 64'(ccr), 64'(0));
    chk("rst2_ready", 64'(in_ready), 64'(1));

    // DW=64, INT_LAT=1
    d_ir = mk(4'h9, 4'h0, 15'h7fff, 1'b0, 32'd0); d_rs2 = 64'h1_0000_0000; d_in_valid = 1'b1;
    tick();
    chk("w64_load", d_result, 64'h0_ffff_fffc);
    d_ir = mk(4'hc, 4'h0, 15'd0, 1'b1, 32'h8000_0000);
    tick();
    chk("w64_jump_pc", d_pc_o, 64'h0000_0000_8000_0000);
    chk("w64_jump_set", 64'(d_pc_set), 64'(1));
    d_ir = mk(4'h6, 4'h0, 15'd0, 1'b0, 32'd0); d_rs1 = 64'd6; d_rs2 = 64'd7;
    tick();
    d_in_valid = 1'b0;
    chk("w64_mul_lat1", d_result, 64'd42);
    chk("w64_mul_valid", 64'(d_out_valid), 64'(1));
    chk("w64_busy", 64'(d_busy), 64'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end
endmodule
